cp0_tlb_sequencer: RTL and testbench

//  Multi-cycle sequencer for TLBP/TLBR/TLBWI. Sits between the decode/issue stage and the CP0 + TLB array.

---
 rtl/sirius_cp0_pkg.sv | 13 +
 rtl/tlb_entry_match.sv | 11 +
 rtl/cp0_tlb_sequencer.sv | 111 +++++++++++
 tb/tb_cp0_tlb_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sirius_cp0_pkg.sv
// sirius_cp0_pkg: shared CP0/TLB types and register addresses
package sirius_cp0_pkg;
  typedef enum logic [1:0] {TLBP = 2'd0, TLBR = 2'd1, TLBWI = 2'd2, RSVD = 2'd3} tlb_op_t;
  localparam logic [7:0] CP0_INDEX = 8'h00;
  localparam logic [7:0] CP0_ENTRYLO0 = 8'h10;
  localparam logic [7:0] CP0_ENTRYLO1 = 8'h18;
  localparam logic [7:0] CP0_ENTRYHI = 8'h50;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } tlb_entry_t;
endpackage

// File: rtl/tlb_entry_match.sv
// tlb_entry_match: VPN2 match plus ASID match unless the entry is global
module tlb_entry_match (
  input  logic [18:0] entry_vpn2,
  input  logic [7:0]  entry_asid,
  input  logic        entry_g,
  input  logic [18:0] vpn2,
  input  logic [7:0]  asid,
  output logic        hit
);
  assign hit = (entry_vpn2 == vpn2) && (entry_g || entry_asid == asid);
endmodule

// File: rtl/cp0_tlb_sequencer.sv
// cp0_tlb_sequencer: multi-cycle TLBP/TLBR/TLBWI engine owning the CP0 write port and TLB array ports
module cp0_tlb_sequencer
  import sirius_cp0_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             busy,
  output logic             done,
  output logic             probe_miss,
  input  logic [31:0]      cp0_entryhi,
  input  logic [31:0]      cp0_entrylo0,
  input  logic [31:0]      cp0_entrylo1,
  input  logic [31:0]      cp0_index,
  output logic             cp0_wen,
  output logic [7:0]       cp0_waddr,
  output logic [31:0]      cp0_wdata,
  output logic [IDX_W-1:0] tlb_idx,
  output logic             tlb_ren,
  output logic             tlb_wen,
  output logic [95:0]      tlb_wdata,
  input  logic [95:0]      tlb_rdata
);
  typedef enum logic [3:0] {
    IDLE, WRITE, READ, RD_WAIT, WB_HI, WB_LO0, WB_LO1, PROBE, PROBE_WB, DONE
  } state_t;
  localparam logic [IDX_W:0] LAST = TLB_ENTRIES[IDX_W:0];
  localparam logic [IDX_W:0] ONE = 1;
  state_t state;
  tlb_entry_t snap, rd;
  logic [IDX_W-1:0] snap_idx;
  logic [IDX_W:0] cnt;
  logic miss, hit, accept, g;
  logic unused_idx;
  assign unused_idx = ^cp0_index[31:IDX_W];
  assign rd = tlb_rdata;
  tlb_entry_match u_match (
    .entry_vpn2(rd.hi[31:13]),
    .entry_asid(rd.hi[7:0]),
    .entry_g(rd.lo0[0]),
    .vpn2(snap.hi[31:13]),
    .asid(snap.hi[7:0]),
    .hit(hit)
  );
  // TLBR reuses the snapshot registers to hold the entry read back from the array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      snap <= '0;
      snap_idx <= '0;
      cnt <= '0;
      miss <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          snap <= {cp0_entryhi, cp0_entrylo0, cp0_entrylo1};
          snap_idx <= cp0_index[IDX_W-1:0];
          cnt <= ONE;
          miss <= 1'b0;
          case (tlb_op_t'(cmd_op))
            TLBWI: state <= WRITE;
            TLBR: state <= READ;
            TLBP: state <= PROBE;
            default: state <= DONE;
          endcase
        end
        WRITE: state <= DONE;
        READ: state <= RD_WAIT;
        RD_WAIT: begin
          snap <= rd;
          state <= WB_HI;
        end
        WB_HI: state <= WB_LO0;
        WB_LO0: state <= WB_LO1;
        WB_LO1: state <= DONE;
        // cnt is the index being read; the data on tlb_rdata belongs to cnt-1
        PROBE: if (hit) begin
          cnt <= cnt - ONE;
          state <= PROBE_WB;
        end else if (cnt == LAST) begin
          miss <= 1'b1;
          state <= PROBE_WB;
        end else cnt <= cnt + ONE;
        PROBE_WB: state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid & cmd_ready;
  assign busy = !cmd_ready;
  assign done = state == DONE;
  assign g = snap.lo0[0] & snap.lo1[0];
  // Entry 0 is read in the accept cycle so the probe result lands on a hit at k+2
  assign tlb_ren = (state == READ) | (state == PROBE && !cnt[IDX_W]) | (accept && tlb_op_t'(cmd_op) == TLBP);
  assign tlb_wen = state == WRITE;
  assign tlb_idx = (state == READ || state == WRITE) ? snap_idx : state == PROBE ? cnt[IDX_W-1:0] : '0;
  assign tlb_wdata = tlb_wen ? {snap.hi[31:13], 5'b0, snap.hi[7:0], snap.lo0[31:1], g, snap.lo1[31:1], g} : '0;
  assign cp0_wen = state inside {WB_HI, WB_LO0, WB_LO1, PROBE_WB};
  assign cp0_waddr = state == WB_HI ? CP0_ENTRYHI : state == WB_LO0 ? CP0_ENTRYLO0 :
                     state == WB_LO1 ? CP0_ENTRYLO1 : CP0_INDEX;
  assign cp0_wdata = state == WB_HI ? snap.hi : state == WB_LO0 ? snap.lo0 : state == WB_LO1 ? snap.lo1 :
                     state == PROBE_WB ? {miss, {(31-IDX_W){1'b0}}, miss ? {IDX_W{1'b0}} : cnt[IDX_W-1:0]} : '0;
  assign probe_miss = state == PROBE_WB && miss;
endmodule

// File: tb/tb_cp0_tlb_sequencer.sv
// tb_cp0_tlb_sequencer: table-driven checks of the TLB sequencer against a behavioural TLB array
module tb_cp0_tlb_sequencer;
  import sirius_cp0_pkg::*;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [31:0] cp0_entryhi = 0, cp0_entrylo0 = 0, cp0_entrylo1 = 0, cp0_index = 0;
  logic cmd_ready, busy, done, probe_miss, cp0_wen, tlb_ren, tlb_wen;
  logic [7:0] cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [3:0] tlb_idx;
  logic [95:0] tlb_wdata, tlb_rdata;
  always #5 clk = ~clk;

  cp0_tlb_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .busy(busy), .done(done), .probe_miss(probe_miss), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
    .cp0_wen(cp0_wen), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .tlb_idx(tlb_idx),
    .tlb_ren(tlb_ren), .tlb_wen(tlb_wen), .tlb_wdata(tlb_wdata), .tlb_rdata(tlb_rdata)
  );

  tlb_entry_t mem [16];
  logic pre_we = 0;
  logic [3:0] pre_idx = 0;
  tlb_entry_t pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (tlb_wen) mem[tlb_idx] <= tlb_wdata;
    if (tlb_ren) tlb_rdata <= mem[tlb_idx];
  end

  logic m_clr = 0;
  logic [31:0] m_hi, m_lo0, m_lo1;
  always @(posedge clk) begin
    if (m_clr) begin
      m_hi <= 32'hDEADBEEF;
      m_lo0 <= 32'hDEADBEEF;
      m_lo1 <= 32'hDEADBEEF;
    end else if (cp0_wen) begin
      if (cp0_waddr == CP0_ENTRYHI) m_hi <= cp0_wdata;
      if (cp0_waddr == CP0_ENTRYLO0) m_lo0 <= cp0_wdata;
      if (cp0_waddr == CP0_ENTRYLO1) m_lo1 <= cp0_wdata;
    end
  end

  int nvec = 0, nerr = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input int i, input tlb_entry_t e);
    @(negedge clk);
    pre_we = 1;
    pre_idx = 4'(i);
    pre_data = e;
    @(negedge clk);
    pre_we = 0;
  endtask

  int done_cyc, nw, ntw, bad, rdy, nbusy;
  int w_cyc [4];
  logic [7:0] w_addr [4];
  logic [31:0] w_data [4];
  logic w_miss [4];
  logic [3:0] tw_idx;
  logic [95:0] tw_data;

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [31:0] hi, lo0, lo1, idx, input bit chg);
    nw = 0; ntw = 0; bad = 0; rdy = 0; nbusy = 0; done_cyc = -1;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op;
    cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; cp0_index = idx;
    @(posedge clk);
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (chg) begin
          cp0_entryhi = 32'h0;
          cmd_op = 2'd2;
        end else cmd_valid = 0;
      end
      if (cp0_wen) begin
        if (nw < 4) begin
          w_cyc[nw] = c; w_addr[nw] = cp0_waddr; w_data[nw] = cp0_wdata; w_miss[nw] = probe_miss;
        end
        nw++;
      end
      if (tlb_wen) begin
        ntw++; tw_idx = tlb_idx; tw_data = tlb_wdata;
      end
      if (int'(cp0_wen) + int'(tlb_wen) + int'(tlb_ren) > 1 || (!cp0_wen && (cp0_waddr != 0 || cp0_wdata != 0)) || (probe_miss && !cp0_wen)) bad++;
      if (cmd_ready) rdy++;
      if (!busy) nbusy++;
      if (done) begin
        done_cyc = c;
        cmd_valid = 0;
      end
    end
    cmd_valid = 0;
    @(negedge clk);
    check({name, " idle_after_done"}, {cmd_ready, busy, done}, 3'b100);
  endtask

  typedef struct {
    logic [1:0] op; logic [31:0] hi, lo0, lo1, idx; bit chg; bit pre; int pi; tlb_entry_t pd;
    int e_done; int e_nw; int e_fcyc; logic [7:0] e_faddr; logic [31:0] e_fdata; logic [31:0] e_mdata;
    int e_lcyc; logic [7:0] e_laddr; logic [31:0] e_ldata; logic e_lmiss;
    int e_ntw; logic [3:0] e_twidx; logic [95:0] e_twdata;
  } vec_t;
  vec_t v [11];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    v[0] = '{op:2'd2, hi:32'hABCDE012, lo0:32'h00000F01, lo1:32'h00000E00, idx:32'hFFFFFFF5, e_done:2, e_ntw:1,
             e_twidx:4'd5, e_twdata:{32'hABCDE012, 32'h00000F00, 32'h00000E00}, default:0};
    v[1] = '{op:2'd1, hi:32'h55555555, idx:32'h5, e_done:6, e_nw:3, e_fcyc:3, e_faddr:8'h50, e_fdata:32'hABCDE012,
             e_mdata:32'h00000F00, e_lcyc:5, e_laddr:8'h18, e_ldata:32'h00000E00, default:0};
    v[2] = '{op:2'd2, hi:32'hFFFFFF34, lo0:32'h00000B01, lo1:32'h00000A01, idx:32'h6, e_done:2, e_ntw:1,
             e_twidx:4'd6, e_twdata:{32'hFFFFE034, 32'h00000B01, 32'h00000A01}, default:0};
    v[3] = '{op:2'd1, idx:32'h6, e_done:6, e_nw:3, e_fcyc:3, e_faddr:8'h50, e_fdata:32'hFFFFE034,
             e_mdata:32'h00000B01, e_lcyc:5, e_laddr:8'h18, e_ldata:32'h00000A01, default:0};
    v[4] = '{op:2'd3, hi:32'h12344042, e_done:1, default:0};
    v[5] = '{op:2'd0, hi:32'h12344042, e_done:6, e_nw:1, e_fcyc:5, e_fdata:32'h3, e_lcyc:5, e_ldata:32'h3, default:0};
    v[6] = '{op:2'd0, hi:32'h12344042, chg:1, e_done:6, e_nw:1, e_fcyc:5, e_fdata:32'h3, e_lcyc:5, e_ldata:32'h3, default:0};
    v[7] = '{op:2'd0, hi:32'h76542011, pre:1, pi:7, pd:{32'h76542099, 32'h1, 32'h0}, e_done:10, e_nw:1,
             e_fcyc:9, e_fdata:32'h7, e_lcyc:9, e_ldata:32'h7, default:0};
    v[8] = '{op:2'd0, hi:32'h76542011, pre:1, pi:7, pd:{32'h76542099, 32'h0, 32'h0}, e_done:18, e_nw:1,
             e_fcyc:17, e_fdata:32'h80000000, e_lcyc:17, e_ldata:32'h80000000, e_lmiss:1, default:0};
    v[9] = '{op:2'd0, hi:32'h0000000F, e_done:18, e_nw:1, e_fcyc:17, e_fdata:32'hF, e_lcyc:17, e_ldata:32'hF, default:0};
    v[10] = '{op:2'd0, hi:32'h0, e_done:3, e_nw:1, e_fcyc:2, e_fdata:32'h0, e_lcyc:2, e_ldata:32'h0, default:0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, busy, done, probe_miss, cp0_wen, tlb_ren, tlb_wen, cp0_waddr, cp0_wdata, tlb_idx},
          {1'b1, 6'b0, 8'h0, 32'h0, 4'h0});
    rst = 0;
    for (int i = 0; i < 16; i++) preload(i, {32'(i), 32'h0, 32'h0});
    preload(3, {32'h12344042, 32'h0, 32'h0});
    preload(9, {32'h12344042, 32'h0, 32'h0});

    for (int i = 0; i < 11; i++) begin
      string n;
      n = $sformatf("v%0d", i);
      if (v[i].pre) preload(v[i].pi, v[i].pd);
      run_cmd(n, v[i].op, v[i].hi, v[i].lo0, v[i].lo1, v[i].idx, v[i].chg);
      check({n, " done_cycle"}, done_cyc, v[i].e_done);
      check({n, " cp0_write_count"}, nw, v[i].e_nw);
      if (v[i].e_nw > 0) begin
        check({n, " first_write"}, {w_cyc[0], w_addr[0], w_data[0]}, {v[i].e_fcyc, v[i].e_faddr, v[i].e_fdata});
        check({n, " last_write"}, {w_cyc[v[i].e_nw-1], w_addr[v[i].e_nw-1], w_data[v[i].e_nw-1], w_miss[v[i].e_nw-1]},
              {v[i].e_lcyc, v[i].e_laddr, v[i].e_ldata, v[i].e_lmiss});
      end
      if (v[i].e_nw == 3) check({n, " mid_write"}, {w_cyc[1], w_addr[1], w_data[1]}, {32'd4, 8'h10, v[i].e_mdata});
      check({n, " tlb_write_count"}, ntw, v[i].e_ntw);
      if (v[i].e_ntw > 0) check({n, " tlb_write"}, {tw_idx, tw_data}, {v[i].e_twidx, v[i].e_twdata});
      check({n, " strobe_rules_violations"}, bad, 0);
      check({n, " ready_or_idle_while_busy"}, rdy + nbusy, 0);
    end

    @(negedge clk); m_clr = 1;
    @(negedge clk); m_clr = 0;
    cmd_valid = 1; cmd_op = 2'd1; cp0_index = 32'h5;
    @(posedge clk);
    @(negedge clk); cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_test wb_hi", {cp0_wen, cp0_waddr, cp0_wdata}, {1'b1, 8'h50, 32'hABCDE012});
    @(negedge clk);
    check("rst_test wb_lo0", {cp0_wen, cp0_waddr, cp0_wdata}, {1'b1, 8'h10, 32'h00000F00});
    rst = 1;
    #1;
    check("rst_test immediate", {cmd_ready, busy, done, probe_miss, cp0_wen, tlb_ren, tlb_wen}, 7'b1000000);
    @(negedge clk);
    check("rst_test next_cycle", {cmd_ready, busy, cp0_wen, tlb_ren, tlb_wen}, 5'b10000);
    rst = 0;
    repeat (3) @(negedge clk);
    check("rst_test cp0_regs", {m_hi, m_lo0, m_lo1}, {32'hABCDE012, 32'hDEADBEEF, 32'hDEADBEEF});
    check("rst_test ready", {cmd_ready, busy, cp0_wen}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
